// File: rtl/pixel_frame_rx.sv
`default_nettype none
// ============================================================================
// pixel_frame_rx : serial 1-bit pixel capture into a row-word frame buffer
// Revision: 1.0
// ============================================================================
module pixel_frame_rx #(
   parameter int NUM_PIXELS = 784,
   parameter int WORD_W     = 28,
   parameter int ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_in,
   input  logic              frame_done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data,
   output logic              frame_valid,
   output logic              busy,
   output logic [9:0]        pix_count,
   output logic              protocol_err
);

   localparam int NUM_WORDS = NUM_PIXELS / WORD_W;
   localparam int BIT_W     = $clog2(WORD_W);
   localparam logic [9:0]        c_last_pix  = 10'(NUM_PIXELS - 1);
   localparam logic [BIT_W-1:0]  c_row_last  = BIT_W'(WORD_W - 1);
   localparam logic [ADDR_W:0]   c_num_words = (ADDR_W + 1)'(NUM_WORDS);

   typedef enum logic [0:0] {
      ST_CAPTURE = 1'b0,
      ST_FULL    = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [WORD_W-1:0]   r_shift;
   logic [BIT_W-1:0]    r_bit_idx;
   logic [ADDR_W-1:0]   r_word_idx;
   logic [9:0]          r_pix_count;
   logic                r_err;
   logic [WORD_W-1:0]   r_mem [NUM_WORDS];

   logic [WORD_W-1:0]   w_word;
   logic                w_row_end;
   logic                w_addr_ok;

   // New bit enters at the MSB so the row's first pixel ends up in bit 0.
   assign w_word    = {data_in, r_shift[WORD_W-1:1]};
   assign w_addr_ok = ({1'b0, rd_addr} < c_num_words);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_CAPTURE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_row_end    = 1'b0;
      case (r_state)
         ST_CAPTURE: begin
            w_row_end = (r_bit_idx == c_row_last);
            if (r_pix_count == c_last_pix) w_state_next = ST_FULL;
         end
         ST_FULL: begin
            if (frame_done) w_state_next = ST_CAPTURE;
         end
         default: w_state_next = ST_CAPTURE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_bit_idx   <= '0;
         r_word_idx  <= '0;
         r_pix_count <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_CAPTURE: begin
               r_shift     <= w_word;
               r_pix_count <= r_pix_count + 10'd1;
               if (frame_done) r_err <= 1'b1;
               if (w_row_end) begin
                  r_bit_idx  <= '0;
                  r_word_idx <= r_word_idx + ADDR_W'(1);
               end else begin
                  r_bit_idx  <= r_bit_idx + BIT_W'(1);
               end
            end
            ST_FULL: begin
               if (frame_done) begin
                  r_shift     <= '0;
                  r_bit_idx   <= '0;
                  r_word_idx  <= '0;
                  r_pix_count <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Buffer is deliberately left uninitialised; frame_valid guards stale rows.
   always_ff @(posedge clk) begin
      if (rst_n && (r_state == ST_CAPTURE) && w_row_end)
         r_mem[r_word_idx] <= w_word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)         rd_data <= '0;
      else if (w_addr_ok) rd_data <= r_mem[rd_addr];
      else                rd_data <= '0;
   end

   assign frame_valid  = (r_state == ST_FULL);
   assign busy         = (r_state == ST_CAPTURE);
   assign pix_count    = r_pix_count;
   assign protocol_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_rx.sv
`default_nettype none
// ============================================================================
// tb_pixel_frame_rx : directed bench with a read-data scoreboard
// Revision: 1.0
// ============================================================================
module tb_pixel_frame_rx;

   localparam int NUM_PIXELS = 784;
   localparam int WORD_W     = 28;
   localparam int ADDR_W     = 5;
   localparam int NUM_WORDS  = NUM_PIXELS / WORD_W;

   logic              clk;
   logic              rst_n;
   logic              data_in;
   logic              frame_done;
   logic [ADDR_W-1:0] rd_addr;
   logic [WORD_W-1:0] rd_data;
   logic              frame_valid;
   logic              busy;
   logic [9:0]        pix_count;
   logic              protocol_err;

   int checks = 0;
   int errors = 0;
   logic [NUM_PIXELS-1:0] exp_frame;
   logic [WORD_W-1:0]     sb_q [$];

   pixel_frame_rx #(.NUM_PIXELS(NUM_PIXELS), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .frame_done(frame_done),
      .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
      .busy(busy), .pix_count(pix_count), .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic pix_bit(input int mode, input int k);
      case (mode)
         0:       return (k % 3 == 0);
         1:       return 1'b1;
         2:       return 1'b0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Drive a read, queue its expected word, then pop and compare one edge later.
   task automatic read_word(input int addr, input string tag);
      logic [WORD_W-1:0] exp;
      exp = (addr < NUM_WORDS) ? exp_frame[addr*WORD_W +: WORD_W] : '0;
      rd_addr = ADDR_W'(addr);
      sb_q.push_back(exp);
      tick();
      if (sb_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
      else                  check(tag, rd_data, sb_q.pop_front());
   endtask

   task automatic read_const(input int addr, input logic [WORD_W-1:0] exp, input string tag);
      rd_addr = ADDR_W'(addr);
      sb_q.push_back(exp);
      tick();
      check(tag, rd_data, sb_q.pop_front());
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < NUM_WORDS; a++) read_word(a, $sformatf("%s_w%0d", tag, a));
   endtask

   task automatic stream(input int mode, input int done_at, input string tag);
      for (int k = 0; k < NUM_PIXELS; k++) begin
         logic b;
         b = pix_bit(mode, k);
         exp_frame[k] = b;
         data_in    = b;
         frame_done = (k == done_at);
         tick();
         frame_done = 1'b0;
         if (k == 99)             check({tag, "_pixcnt_mid"}, pix_count, 100);
         if (k == NUM_PIXELS - 2) check({tag, "_fv_early"}, frame_valid, 0);
      end
      check({tag, "_fv_rise"}, frame_valid, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_pixcnt"}, pix_count, NUM_PIXELS);
   endtask

   task automatic rearm(input string tag);
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      check({tag, "_fv"}, frame_valid, 0);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_pixcnt"}, pix_count, 0);
   endtask

   initial begin
      rst_n = 1'b0; data_in = 1'b0; frame_done = 1'b0; rd_addr = '0;
      repeat (3) tick();
      check("rst_fv", frame_valid, 0);
      check("rst_busy", busy, 1);
      check("rst_pixcnt", pix_count, 0);
      check("rst_err", protocol_err, 0);
      check("rst_rd", rd_data, 0);

      rst_n = 1'b1;
      stream(0, -1, "f0");
      read_const(0, 28'h9249249, "f0_row0");
      read_const(2, 28'h2492492, "f0_row2");
      read_all("f0");

      for (int i = 0; i < 200; i++) begin
         data_in = 1'($urandom_range(0, 1));
         tick();
      end
      check("idle_fv", frame_valid, 1);
      check("idle_pixcnt", pix_count, NUM_PIXELS);
      read_all("idle");

      rearm("ra1");
      stream(1, -1, "ones");
      read_const(5, 28'hFFFFFFF, "ones_row5");
      read_all("ones");

      rearm("ra2");
      stream(2, -1, "zeros");
      read_const(13, 28'h0000000, "zeros_row13");
      read_all("zeros");
      check("err_clean", protocol_err, 0);

      rearm("ra3");
      stream(3, 400, "perr");
      check("perr_set", protocol_err, 1);
      read_all("perr");
      check("perr_sticky", protocol_err, 1);

      rearm("ra4");
      for (int k = 0; k < 500; k++) begin
         data_in = 1'b1;
         tick();
      end
      rst_n = 1'b0;
      tick();
      check("mrst_fv", frame_valid, 0);
      check("mrst_busy", busy, 1);
      tick();
      check("mrst_pixcnt", pix_count, 0);
      check("mrst_err", protocol_err, 0);
      check("mrst_rd", rd_data, 0);
      rst_n = 1'b1;
      stream(3, -1, "fresh");
      read_all("fresh");

      for (int a = NUM_WORDS; a < (1 << ADDR_W); a++)
         read_word(a, $sformatf("oor_%0d", a));
      read_word(NUM_WORDS - 1, "last_row");

      rst_n = 1'b0;
      tick();
      check("frst_fv", frame_valid, 0);
      check("frst_busy", busy, 1);
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
